fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  RV32I instruction fetch stage, directly upstream of the decode control unit.
//  - Owns the PC and issues in-order word requests to instruction memory.
//  - Buffers returned instructions in a small queue.
//  - Presents {inst, pc} with a valid/ready handshake to decode.
//  - Squashes in-flight fetches on an EX-stage redirect (taken branch / jal / jalr).
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC loaded on reset
//  FIFO_DEPTH    4              instruction queue entries; also the max in-flight requests (power of 2, >=2)
// PORTS
//  clk             in   1   clock, rising edge
//  rst_n           in   1   asynchronous active-low reset
//  imem_req        out  1   request valid
//  imem_addr       out  32  word-aligned fetch address (bits[1:0]=0)
//  imem_gnt        in   1   request accepted this cycle
//  imem_rvalid     in   1   response valid; in order, >=1 cycle after gnt
//  imem_rdata      in   32  instruction word
//  redirect        in   1   flush and restart fetch at redirect_pc
//  redirect_pc     in   32  new PC; bits[1:0] ignored (forced 0)
//  id_valid        out  1   id_inst/id_pc hold a real instruction
//  id_ready        in   1   decode accepts; low = stall
//  id_inst         out  32  instruction to decode; 32'h0000_0013 (nop) when !id_valid
//  id_pc           out  32  PC of id_inst; 0 when !id_valid
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - pc=RESET_VECTOR; queue empty; outstanding=0; drop_cnt=0.
//   - imem_req=0, id_valid=0, id_inst=32'h13, id_pc=0.
//   - First imem_req is asserted in the first cycle after deassertion.
//  Issue:
//   - imem_req = !redirect && (outstanding + q_count < FIFO_DEPTH); imem_addr=pc.
//   - On imem_req&&imem_gnt: pc<=pc+4 (mod 2^32, wrap silently); outstanding++.
//   - The credit rule guarantees the queue never overflows; no backpressure to imem.
//  Response:
//   - On imem_rvalid: outstanding--.
//   - If drop_cnt>0: drop_cnt--, word discarded. Else push {rdata, addr} to queue.
//   - Response PC is tracked by a resp_pc register, +4 per accepted response.
//  Output (registered queue head):
//   - Word pushed in cycle N is visible at id_valid no earlier than N+1.
//   - Pop when id_valid&&id_ready. Push and pop in the same cycle are both legal, including when full.
//   - id_* hold stable while id_valid&&!id_ready.
//  Redirect (highest priority):
//   - pc<=redirect_pc&~3 and resp_pc<=redirect_pc&~3; queue flushed.
//   - drop_cnt<=outstanding, counting a same-cycle gnt and excluding a same-cycle rvalid.
//   - id_valid=0 the next cycle; imem_req=0 in the redirect cycle.
//   - Redirect during an existing drop window accumulates correctly; drop_cnt never underflows.
//  Boundaries:
//   - Queue empty with id_ready=1: id_valid=0, nop output.
//   - rvalid with outstanding==0: ignored (sim assertion fires).
//   - pc=32'hFFFF_FFFC +4 wraps to 0.
// CONFIGURATION
//  FETCH_PERF_CNT_EN:
//   - Defined: adds outputs perf_fetched[31:0], incremented per instruction popped to decode,
//     and perf_stall[31:0], incremented per cycle id_valid&&!id_ready.
//   - Both reset to 0 and wrap.
//   - Not defined: ports and counters absent.
// STRUCTURE
//  Package rv32i_types: add NOP_INST=32'h0000_0013 and typedef fetch_pkt_t {inst[31:0], pc[31:0]}.
//  One sub-module fetch_queue:
//   - Sync FIFO of fetch_pkt_t, depth FIFO_DEPTH, with push/pop/flush/count.
//   - fetch_stage instantiates it; PC, credit and drop logic stay in fetch_stage.
// TESTING
//  1. Reset release, imem gnt every cycle, rvalid 1 cycle later, id_ready=1
//     -> addrs 0,4,8,...; id_pc 0,4,8 back-to-back from cycle 3.
//  2. id_ready=0 for 10 cycles with zero-latency-gnt memory
//     -> exactly FIFO_DEPTH=4 requests issued; id_* stable; no loss after release.
//  3. 3 requests in flight, redirect to 32'h100
//     -> 3 stale responses dropped; next id_pc=32'h100.
//  4. Redirect coincident with gnt and rvalid
//     -> granted word dropped, rvalid word discarded, drop_cnt correct; next id_pc=target.
//  5. redirect_pc=32'h203 -> imem_addr=32'h200.
//     Start at pc=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0.
//  6. rst_n low mid-stream
//     -> outputs reset immediately (async); refetch from RESET_VECTOR.
//     With FETCH_PERF_CNT_EN: counts match popped/stalled cycles.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I fetch-path types: canonical NOP encoding and the fetch packet
// handed from fetch to decode.
package rv32i_types;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch packets with push/pop/flush and an occupancy count.
// The head entry is read straight from the storage array, so a word pushed in
// one cycle becomes visible at the head the following cycle.
module fetch_queue
  import rv32i_types::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  fetch_pkt_t  push_pkt_i,
  output fetch_pkt_t  head_pkt_o,
  output logic [AW:0] count_o
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  fetch_pkt_t    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // A pop frees the slot that a same-cycle push may reuse, so push is legal when full.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FULL) || do_pop);

  // Pointer and count next state; flush empties the queue outright.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful below count_q, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_pkt_i;
  end

  assign head_pkt_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: owns the PC, issues in-order word requests under a
// credit limit, queues returned words and hands {inst, pc} to decode.
// A redirect flushes the queue and discards every response still in flight.
// Optional: define FETCH_PERF_CNT_EN for perf_fetched / perf_stall counters.
module fetch_stage
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int unsigned   CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] q_count;
  logic [CW:0]   credit_used;
  logic [31:0]   target;
  logic          fire, rsp, push, pop;
  fetch_pkt_t    push_pkt, head_pkt;

  assign target      = redirect_pc & ~32'h3;
  assign credit_used = {1'b0, outst_q} + {1'b0, q_count};
  // In-flight plus queued words never exceed the queue depth, so responses always fit.
  assign imem_req    = rst_n && !redirect && (credit_used < {1'b0, DEPTH_C});
  assign imem_addr   = pc_q;
  assign fire        = imem_req && imem_gnt;
  assign rsp         = imem_rvalid && (outst_q != '0);
  assign push        = rsp && (drop_q == '0) && !redirect;
  assign pop         = id_valid && id_ready;
  assign push_pkt    = '{inst: imem_rdata, pc: resp_pc_q};

  // PC, credit and drop-window next state; redirect has priority.
  always_comb begin
    outst_d   = outst_q + CW'(fire) - CW'(rsp);
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    drop_d    = drop_q;
    if (redirect) begin
      // Everything still outstanding after this edge is stale, including any
      // words already in an earlier drop window.
      pc_d      = target;
      resp_pc_d = target;
      drop_d    = outst_d;
    end else begin
      if (fire) pc_d = pc_q + 32'd4;
      if (rsp) begin
        if (drop_q != '0) drop_d    = drop_q - 1'b1;
        else              resp_pc_d = resp_pc_q + 32'd4;
      end
    end
  end

  // PC, response PC, outstanding and drop registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_VECTOR;
      resp_pc_q <= RESET_VECTOR;
      outst_q   <= '0;
      drop_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
    end
  end

  fetch_queue #(
    .DEPTH (FIFO_DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (redirect),
    .push_i     (push),
    .pop_i      (pop),
    .push_pkt_i (push_pkt),
    .head_pkt_o (head_pkt),
    .count_o    (q_count)
  );

  assign id_valid = (q_count != '0);
  assign id_inst  = id_valid ? head_pkt.inst : NOP_INST;
  assign id_pc    = id_valid ? head_pkt.pc   : '0;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  // Free-running wrap-around counters of delivered instructions and stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (pop)                  perf_fetched_q <= perf_fetched_q + 32'd1;
      if (id_valid && !id_ready) perf_stall_q  <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

  a_rvalid_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n) imem_rvalid |-> (outst_q != '0)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a randomized instruction memory and a
// queue/epoch reference model of the fetch-to-decode stream.
module tb_fetch_stage;
  import rv32i_types::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall;
  int unsigned m_fetched, m_stall;
`endif

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_VECTOR (RV),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_inst     (id_inst),
    .id_pc       (id_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  // Memory request in flight: address seen by memory, PC decode should see, epoch, due cycle.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_pc;
    int unsigned epoch;
    int unsigned due;
  } req_t;

  req_t        pend[$];
  logic [31:0] expq[$];
  logic [31:0] issue_pc;
  int unsigned epoch;
  int unsigned cyc;
  int unsigned fires;
  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned p_gnt, p_rdy, p_redir, lat_min, lat_max;
  logic        force_redir;
  logic [31:0] force_tgt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[31:16]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_knobs(input int unsigned g, input int unsigned r, input int unsigned d,
                           input int unsigned lmin, input int unsigned lmax);
    p_gnt = g; p_rdy = r; p_redir = d; lat_min = lmin; lat_max = lmax;
  endtask

  // One clock: drive after the rising edge, check and advance the model on the falling edge.
  task automatic run_cycle();
    logic        redir, exp_req;
    logic [31:0] tgt;
    req_t        r;
    @(posedge clk);
    #1;
    cyc++;
    redir = force_redir || ($urandom_range(99) < p_redir);
    if (force_redir)                tgt = force_tgt;
    else if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(15));
    else                            tgt = $urandom;
    force_redir = 1'b0;
    redirect    = redir;
    redirect_pc = tgt;
    imem_gnt    = ($urandom_range(99) < p_gnt);
    id_ready    = ($urandom_range(99) < p_rdy);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end

    @(negedge clk);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_stall", perf_stall, m_stall);
`endif
    check("id_valid", {31'b0, id_valid}, {31'b0, expq.size() > 0});
    if (expq.size() > 0) begin
      check("id_pc", id_pc, expq[0]);
      check("id_inst", id_inst, mem_word(expq[0]));
    end else begin
      check("id_pc_idle", id_pc, 32'h0);
      check("id_inst_idle", id_inst, NOP_INST);
    end
    exp_req = !redir && (pend.size() + expq.size() < DEPTH);
    check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});

    if (imem_req && imem_gnt) begin
      fires++;
      check("imem_addr", imem_addr, issue_pc);
      pend.push_back('{addr: imem_addr, exp_pc: issue_pc, epoch: epoch,
                       due: cyc + $urandom_range(lat_max, lat_min)});
      issue_pc = issue_pc + 32'd4;
    end
`ifdef FETCH_PERF_CNT_EN
    if (expq.size() > 0 && !id_ready) m_stall++;
    if (expq.size() > 0 && id_ready)  m_fetched++;
`endif
    if (expq.size() > 0 && id_ready) void'(expq.pop_front());
    if (imem_rvalid) begin
      r = pend.pop_front();
      if (!redir && r.epoch == epoch) expq.push_back(r.exp_pc);
    end
    if (redir) begin
      epoch++;
      expq.delete();
      issue_pc = tgt & ~32'h3;
    end
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic do_reset();
    @(posedge clk);
    #2;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    redirect    = 1'b0;
    id_ready    = 1'b0;
    rst_n       = 1'b0;
    #1;
    check("rst_imem_req", {31'b0, imem_req}, 32'h0);
    check("rst_id_valid", {31'b0, id_valid}, 32'h0);
    check("rst_id_inst", id_inst, NOP_INST);
    check("rst_id_pc", id_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_perf_fetched", perf_fetched, 32'h0);
    check("rst_perf_stall", perf_stall, 32'h0);
    m_fetched = 0;
    m_stall   = 0;
`endif
    pend.delete();
    expq.delete();
    epoch++;
    issue_pc = RV;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Redirect next cycle, then the first instruction delivered must come from the target.
  task automatic redirect_and_wait(input logic [31:0] tgt, input string tag);
    logic found;
    found       = 1'b0;
    force_redir = 1'b1;
    force_tgt   = tgt;
    run_cycle();
    for (int i = 0; i < 40; i++) begin
      run_cycle();
      if (id_valid) begin
        found = 1'b1;
        break;
      end
    end
    if (found) check(tag, id_pc, tgt & ~32'h3);
    else       check({tag, "_timeout"}, 32'h0, 32'h1);
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    id_ready    = 1'b0;
    force_redir = 1'b0;
    force_tgt   = '0;
    issue_pc    = RV;
    epoch       = 0;
    cyc         = 0;
    fires       = 0;
    n_checks    = 0;
    n_errors    = 0;
`ifdef FETCH_PERF_CNT_EN
    m_fetched   = 0;
    m_stall     = 0;
`endif
    set_knobs(0, 0, 0, 1, 1);
    do_reset();

    // Streaming: grant every cycle, one-cycle latency, decode always ready.
    set_knobs(100, 100, 0, 1, 1);
    repeat (20) run_cycle();

    // Decode stalled: the credit limit allows exactly DEPTH requests.
    do_reset();
    set_knobs(100, 0, 0, 1, 1);
    fires = 0;
    repeat (10) run_cycle();
    check("stall_reqs", fires, DEPTH);
    set_knobs(100, 100, 0, 1, 1);
    repeat (15) run_cycle();

    // Three requests in flight, then redirect.
    do_reset();
    set_knobs(100, 100, 0, 5, 5);
    repeat (3) run_cycle();
    redirect_and_wait(32'h0000_0100, "redir_inflight");
    repeat (10) run_cycle();

    // Redirect in the same cycle as a response and an offered grant.
    do_reset();
    set_knobs(100, 100, 0, 2, 2);
    repeat (2) run_cycle();
    redirect_and_wait(32'h0000_0040, "redir_coincident");
    repeat (10) run_cycle();

    // Misaligned redirect target, then PC wrap past the top of memory.
    do_reset();
    set_knobs(100, 100, 0, 1, 1);
    force_redir = 1'b1;
    force_tgt   = 32'h0000_0203;
    run_cycle();
    run_cycle();
    check("redir_align", imem_addr, 32'h0000_0200);
    redirect_and_wait(32'hFFFF_FFF8, "wrap_first");
    repeat (12) run_cycle();

    // Random traffic with redirects, interrupted by an asynchronous reset.
    set_knobs(70, 60, 5, 1, 4);
    repeat (400) run_cycle();
    do_reset();
    repeat (2000) run_cycle();
    set_knobs(40, 30, 8, 1, 6);
    repeat (1500) run_cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
